dpram_arbiter: RTL and testbench
================================

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, RAM word width in bits.
REQ-002 The block SHALL have parameter ADDRWIDTH, default 8, RAM address width in bits.
REQ-003 The block SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have ports req0/req1/req2  input  1 each  access request, held until ack.
REQ-006 The block SHALL have ports addr0/addr1/addr2  input  ADDRWIDTH each  requester address.
REQ-007 The block SHALL have ports wdata0/wdata1/wdata2  input  DATAWIDTH each  requester write data.
REQ-008 The block SHALL have ports we0/we1/we2  input  1 each  1 = write, 0 = read.
REQ-009 The block SHALL have ports ack0/ack1/ack2  output  1 each  one-cycle completion pulse.
REQ-010 The block SHALL have port rdata  output  DATAWIDTH  result word, valid while any ack is high.
REQ-011 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 The block SHALL have port grant  output  2  index of current/last granted requester.
REQ-013 The block SHALL have ports ram_address  output  ADDRWIDTH,  ram_data  output  DATAWIDTH,  ram_wren  output  1, all to one RAM port.
REQ-014 The block SHALL have port ram_q  input  DATAWIDTH  registered RAM output, 1-cycle read latency, write-through on write.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS, WAIT; IDLE->ACCESS when an eligible request exists; ACCESS->WAIT always; WAIT->IDLE always.
REQ-016 In IDLE the block SHALL treat a requester as eligible when reqN=1 and ackN=0 in that cycle.
REQ-017 In IDLE the winner SHALL be chosen round-robin: search order starts at (last_grant+1) mod 3.
REQ-018 On leaving IDLE the block SHALL register the winner's addr, wdata and we into ram_address, ram_data, and an internal we latch, and update grant and last_grant.
REQ-019 ram_wren SHALL be high only during ACCESS and only when the latched we is 1.
REQ-020 At the end of WAIT the block SHALL register ram_q into rdata and pulse ackN of the granted requester for exactly one cycle (the following IDLE cycle).
REQ-021 Latency from request sampled in IDLE (cycle T) to ack SHALL be 3 cycles (ack high in T+3); peak throughput one access per 3 cycles.
REQ-022 For a write, rdata SHALL return the written word (write-through).
REQ-023 Changes to reqN, addrN, wdataN or weN after grant SHALL NOT affect the transaction in flight; the transaction SHALL complete and ack SHALL still pulse.
REQ-024 At most one ack SHALL be high in any cycle.
REQ-025 rdata SHALL hold its value between acks.

Reset
REQ-026 While reset_n=0 at a clock edge: state <= IDLE, ack0..2 <= 0, ram_wren <= 0, busy <= 0, grant <= 0, last_grant <= 2, rdata <= 0, ram_address <= 0, ram_data <= 0.
REQ-027 Reset asserted during ACCESS or WAIT SHALL abort the transaction with no ack issued; a RAM write already performed is not undone.

Configuration
REQ-028 Macro DPRAM_ARBITER_PRIORITY_EN: when defined, requester 0 SHALL win whenever eligible in IDLE, requesters 1 and 2 round-robin among themselves; when undefined, all three SHALL be pure round-robin per REQ-017.

Verification
REQ-029 Reset, then req1=1, we1=1, addr1=0x10, wdata1=0xA5 -> ram_wren=1 in cycle T+1 only, ack1 high in T+3, rdata=0xA5, grant=1.
REQ-030 After REQ-029, req0=1, we0=0, addr0=0x10 -> ack0 at T+3 with rdata=0xA5.
REQ-031 req0, req1, req2 all held continuously from reset -> ack order 0,1,2,0,1,2 (macro undefined), acks spaced 3 cycles apart, never two acks in one cycle.
REQ-032 Same stimulus with DPRAM_ARBITER_PRIORITY_EN defined and requesters re-raising req the cycle after ack -> requester 0 granted in every arbitration where eligible.
REQ-033 reset_n=0 in the ACCESS cycle of a write to 0x20 -> no ack, busy=0 next cycle, state IDLE, subsequent request served from requester 0.
REQ-034 req2 dropped the cycle after grant -> ack2 still pulses at T+3 with valid rdata; no repeat grant to requester 2.

Source files
------------

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: three-requester arbiter onto one registered RAM port; define DPRAM_ARBITER_PRIORITY_EN to give requester 0 fixed priority
module dpram_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 req2,
  input  logic [ADDRWIDTH-1:0] addr0,
  input  logic [ADDRWIDTH-1:0] addr1,
  input  logic [ADDRWIDTH-1:0] addr2,
  input  logic [DATAWIDTH-1:0] wdata0,
  input  logic [DATAWIDTH-1:0] wdata1,
  input  logic [DATAWIDTH-1:0] wdata2,
  input  logic                 we0,
  input  logic                 we1,
  input  logic                 we2,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 ack2,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 busy,
  output logic [1:0]           grant,
  output logic [ADDRWIDTH-1:0] ram_address,
  output logic [DATAWIDTH-1:0] ram_data,
  output logic                 ram_wren,
  input  logic [DATAWIDTH-1:0] ram_q
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  state_t               r_state, w_next;
  logic [1:0]           r_grant, r_last, w_win;
  logic [2:0]           r_ack, w_elig;
  logic                 r_we, w_take;
  logic [ADDRWIDTH-1:0] r_addr;
  logic [DATAWIDTH-1:0] r_data, r_rdata;
  // a requester whose ack is showing this cycle has just been served and sits out
  assign w_elig = {req2, req1, req0} & ~r_ack;
  assign w_take = (r_state == IDLE) && (|w_elig);
`ifdef DPRAM_ARBITER_PRIORITY_EN
  // requester 0 always wins; 1 and 2 alternate based on the last grant
  always_comb begin
    w_win = w_elig[0] ? 2'd0 : (r_last == 2'd1) ? (w_elig[2] ? 2'd2 : 2'd1) : (w_elig[1] ? 2'd1 : 2'd2);
  end
`else
  logic [1:0] w_c0, w_c1, w_c2;
  // rotating search starting one past the last winner
  always_comb begin
    w_c0  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_c1  = (w_c0 == 2'd2) ? 2'd0 : w_c0 + 2'd1;
    w_c2  = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    w_win = w_elig[w_c0] ? w_c0 : w_elig[w_c1] ? w_c1 : w_c2;
  end
`endif
  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: one access cycle, one RAM latency cycle, back to idle
  always_comb begin
    w_next = (r_state == IDLE) ? (w_take ? ACCESS : IDLE) : (r_state == ACCESS) ? WAIT : IDLE;
  end
  // capture the winner's request, then return the RAM word with an ack
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ack   <= '0;
      r_grant <= 2'd0;
      r_last  <= 2'd2;
      r_rdata <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_ack <= (r_state == WAIT) ? 3'b001 << r_grant : 3'b000;
      if (r_state == WAIT) r_rdata <= ram_q;
      if (w_take) begin
        r_grant <= w_win;
        r_last  <= w_win;
        r_addr  <= (w_win == 2'd0) ? addr0 : (w_win == 2'd1) ? addr1 : addr2;
        r_data  <= (w_win == 2'd0) ? wdata0 : (w_win == 2'd1) ? wdata1 : wdata2;
        r_we    <= (w_win == 2'd0) ? we0 : (w_win == 2'd1) ? we1 : we2;
      end
    end
  end
  assign ack0        = r_ack[0];
  assign ack1        = r_ack[1];
  assign ack2        = r_ack[2];
  assign rdata       = r_rdata;
  assign busy        = (r_state != IDLE);
  assign grant       = r_grant;
  assign ram_address = r_addr;
  assign ram_data    = r_data;
  assign ram_wren    = (r_state == ACCESS) && r_we;
endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: directed and random requests against a transaction-level model with a registered RAM
module tb_dpram_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    req = '0;
  logic [2:0]    we = '0;
  logic [AW-1:0] addr [3];
  logic [DW-1:0] wdata [3];
  logic          ack0, ack1, ack2, busy, ram_wren;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_address;
  logic [1:0]    grant;
  logic [DW-1:0] ram [2**AW] = '{default: '0};
  int            n_chk = 0;
  int            n_err = 0;
  // reference: memory image plus the single transaction in flight, tracked by its age
  logic [DW-1:0] mmem [2**AW] = '{default: '0};
  int            m_age = 0;
  int            m_who = 0;
  int            m_last = 2;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_we = 1'b0;
  logic [2:0]    e_ack = '0;
  logic [DW-1:0] e_rdata = '0;
  logic [1:0]    e_grant = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  dpram_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req[0]), .req1(req[1]), .req2(req[2]),
    .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]),
    .wdata0(wdata[0]), .wdata1(wdata[1]), .wdata2(wdata[2]),
    .we0(we[0]), .we1(we[1]), .we2(we[2]),
    .ack0(ack0), .ack1(ack1), .ack2(ack2),
    .rdata(rdata), .busy(busy), .grant(grant),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );
  always #5 clock = ~clock;
  // registered single-port RAM, write-through
  always @(posedge clock) begin
    if (ram_wren) begin
      ram[ram_address] <= ram_data;
      ram_q <= ram_data;
    end else ram_q <= ram[ram_address];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pick(input logic [2:0] el);
`ifdef DPRAM_ARBITER_PRIORITY_EN
    if (el[0]) return 0;
    if (m_last == 1) return el[2] ? 2 : 1;
    return el[1] ? 1 : 2;
`else
    for (int k = 1; k <= 3; k++) if (el[(m_last + k) % 3]) return (m_last + k) % 3;
    return 0;
`endif
  endfunction
  // advance the reference by one clock using the inputs currently driven
  task automatic step();
    logic [2:0] el;
    int w;
    el = req & ~e_ack;
    if (m_age == 1 && m_we) mmem[m_addr] = m_wdata;
    if (!reset_n) begin
      m_age = 0; e_ack = '0; e_rdata = '0; e_grant = '0; m_last = 2; e_addr = '0; e_data = '0;
    end else begin
      e_ack = '0;
      if (m_age == 2) begin
        e_ack[m_who] = 1'b1;
        e_rdata = mmem[m_addr];
        m_age = 0;
      end else if (m_age == 1) m_age = 2;
      else if (el != 3'b000) begin
        w = pick(el);
        m_who = w; m_addr = addr[w]; m_wdata = wdata[w]; m_we = we[w];
        m_age = 1; m_last = w; e_grant = 2'(w); e_addr = m_addr; e_data = m_wdata;
      end
    end
  endtask
  task automatic cycle();
    step();
    @(posedge clock);
    @(negedge clock);
    chk("ack", 32'({ack2, ack1, ack0}), 32'(e_ack));
    chk("ack_onehot", 32'($countones({ack2, ack1, ack0}) <= 1), 32'd1);
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("busy", 32'(busy), 32'(m_age != 0));
    chk("grant", 32'(grant), 32'(e_grant));
    chk("wren", 32'(ram_wren), 32'(m_age == 1 && m_we));
    chk("ram_address", 32'(ram_address), 32'(e_addr));
    chk("ram_data", 32'(ram_data), 32'(e_data));
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask
  task automatic drive_random();
    reset_n = ($urandom_range(63) != 0);
    for (int i = 0; i < 3; i++) begin
      if (!req[i] || e_ack[i] || (m_age != 0 && m_who == i && $urandom_range(3) == 0)) begin
        req[i] = 1'($urandom_range(1));
        addr[i] = AW'($urandom_range(7));
        wdata[i] = DW'($urandom);
        we[i] = 1'($urandom_range(1));
      end
    end
  endtask
  initial begin
    int t_ack [$];
    int who [$];
    int cyc;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
    end
    do_reset();
    // single write from requester 1, then read-back by requester 0
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h10; wdata[1] = 8'hA5;
    cycle();
    chk("w_wren_t1", 32'(ram_wren), 32'd1);
    cycle();
    chk("w_wren_t2", 32'(ram_wren), 32'd0);
    cycle();
    chk("w_ack1", 32'(ack1), 32'd1);
    chk("w_rdata", 32'(rdata), 32'hA5);
    chk("w_grant", 32'(grant), 32'd1);
    req[1] = 1'b0; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h10;
    cycle(); cycle(); cycle();
    chk("r_ack0", 32'(ack0), 32'd1);
    chk("r_rdata", 32'(rdata), 32'hA5);
    req[0] = 1'b0;
    cycle();
    chk("r_hold", 32'(rdata), 32'hA5);
    // all three held continuously
    do_reset();
    we = '0;
    req = 3'b111;
    cyc = 0;
    for (int n = 0; n < 18; n++) begin
      cycle();
      cyc++;
      if (ack0 | ack1 | ack2) begin
        t_ack.push_back(cyc);
        who.push_back(ack0 ? 0 : ack1 ? 1 : 2);
      end
    end
`ifndef DPRAM_ARBITER_PRIORITY_EN
    chk("rr_count", 32'(who.size()), 32'd6);
    for (int i = 0; i < who.size(); i++) chk("rr_order", 32'(who[i]), 32'(i % 3));
    for (int i = 1; i < t_ack.size(); i++) chk("rr_gap", 32'(t_ack[i] - t_ack[i-1]), 32'd3);
`endif
    // reset during the access cycle of a write
    do_reset();
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h20; wdata[1] = 8'h3C;
    cycle();
    chk("abort_in_access", 32'(busy), 32'd1);
    reset_n = 1'b0;
    req = '0;
    cycle();
    chk("abort_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    cycle(); cycle(); cycle();
    chk("abort_noack", 32'({ack2, ack1, ack0}), 32'd0);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h20;
    cycle();
    chk("abort_next_grant", 32'(grant), 32'd0);
    cycle(); cycle();
    chk("abort_next_ack0", 32'(ack0), 32'd1);
    chk("abort_write_kept", 32'(rdata), 32'h3C);
    req[0] = 1'b0;
    // requester 2 drops its request right after grant
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 8'h10;
    cycle();
    req[2] = 1'b0; addr[2] = 8'h20; we[2] = 1'b1;
    cycle(); cycle();
    chk("drop_ack2", 32'(ack2), 32'd1);
    chk("drop_rdata", 32'(rdata), 32'hA5);
    for (int n = 0; n < 4; n++) begin
      cycle();
      chk("drop_no_regrant", 32'(busy), 32'd0);
    end
    // random traffic including mid-flight changes and occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
